// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size codes follow the RISC-V func3 encoding of loads and stores.
package lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [3:0] be_gen(
        input logic [2:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (size)
            SZ_B, SZ_BU: be = 4'b0001 << off;
            SZ_H, SZ_HU: be = 4'b0011 << off;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Illegal sizes are folded into the misaligned class: no access is made
    function automatic logic bad_access(
        input logic [2:0] size,
        input logic [1:0] off
    );
        logic bad;
        case (size)
            SZ_B, SZ_BU: bad = 1'b0;
            SZ_H, SZ_HU: bad = off[0];
            SZ_W:        bad = |off;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the LSU and memory.
// The LSU is the master; memory is the slave.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rd;

    modport master (
        output req, we, be, addr, wd,
        input  ready, rvalid, rd
    );

    modport slave (
        input  req, we, be, addr, wd,
        output ready, rvalid, rd
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension.
// Pure combinational; the offset is assumed already legal for the size.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] data
);
    logic [31:0] sh;

    assign sh = word >> {off, 3'b000};

    always_comb begin
        data = word;
        case (size)
            SZ_B:    data = {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   data = {24'b0, sh[7:0]};
            SZ_H:    data = {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   data = {16'b0, sh[15:0]};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one outstanding access at a time,
// stalls the core until the access finishes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic              core_stall_o,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              load_valid_o,
    output logic              misalign_o,
    load_store_unit_if.master mem
);
    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              req_q, req_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              lv_q, lv_d;
    logic              mis_q, mis_d;
    logic [DATA_W-1:0] wd_sel;
    logic [DATA_W-1:0] aligned;

    lsu_load_align u_align (
        .word (mem.rd),
        .off  (off_q),
        .size (size_q),
        .data (aligned)
    );

    always_comb begin
        wd_sel = core_wd_i;
        unique case (core_size_i[1:0])
            2'b00:   wd_sel = {4{core_wd_i[7:0]}};
            2'b01:   wd_sel = {2{core_wd_i[15:0]}};
            default: wd_sel = core_wd_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        req_d   = req_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        lv_d    = 1'b0;
        mis_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (bad_access(core_size_i, core_addr_i[1:0])) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        we_d    = core_we_i;
                        size_d  = core_size_i;
                        off_d   = core_addr_i[1:0];
                        be_d    = be_gen(core_size_i, core_addr_i[1:0]);
                        addr_d  = {core_addr_i[ADDR_W-1:2], 2'b00};
                        wd_d    = wd_sel;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.ready) begin
                    req_d   = 1'b0;
                    state_d = we_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (mem.rvalid) begin
                    rd_d    = aligned;
                    lv_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'b0;
            off_q   <= 2'b0;
            req_q   <= 1'b0;
            be_q    <= 4'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            req_q   <= req_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            lv_q    <= lv_d;
            mis_q   <= mis_d;
        end
    end

    assign core_stall_o = (state_q == IDLE && core_req_i)
                        || state_q == REQ
                        || state_q == RESP;
    assign core_rd_o    = rd_q;
    assign load_valid_o = lv_q;
    assign misalign_o   = mis_q;
    assign mem.req      = req_q;
    assign mem.we       = we_q;
    assign mem.be       = be_q;
    assign mem.addr     = addr_q;
    assign mem.wd       = wd_q;
endmodule
